seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
- Parametrised sequential shift-add multiplier: control FSM, iteration counter, (WIDTH+1)-bit add/sub unit and product register in one block.
- Supports unsigned mode (shift-add) and signed two's-complement mode (radix-2 Booth).
- Uses a start/busy/done handshake and holds the result until the next start.
- Sits beside the ALU as the multiply execution unit feeding HI/LO.

Parameters:
WIDTH, 32, operand width in bits (min 4); product is 2*WIDTH bits
CNT_W, $clog2(WIDTH+1), iteration counter width (derived, do not override)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
signed_mode  input  1  0 = unsigned, 1 = signed two's complement; latched at accept
multiplicand  input  WIDTH  operand A; latched at accept
multiplier  input  WIDTH  operand B; latched at accept
busy  output  1  high while an operation is in flight
done  output  1  one-cycle pulse when the result becomes valid
product  output  2*WIDTH  full result
hi  output  WIDTH  product[2W-1:W]
lo  output  WIDTH  product[W-1:0]

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - State = IDLE; busy=0, done=0.
  - Product register, multiplicand latch, Booth bit q_m1 and counter all cleared.
  - product, hi, lo = 0.
- Internal registers:
  - acc: WIDTH+1 bits.
  - preg: WIDTH bits, initially the multiplier.
  - q_m1: 1 bit.
  - mcand: WIDTH+1 bits, zero-extended in unsigned mode, sign-extended in signed mode.
  - product = {acc[WIDTH-1:0], preg}.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 -> load acc=0, preg=multiplier, q_m1=0, latch mcand and mode, cnt=WIDTH; go to RUN; busy=1 from the next cycle.
  - RUN, one iteration per cycle:
    - Unsigned: if preg[0]=1, sum = acc+mcand (WIDTH+1 bits, carry kept in acc[WIDTH]); else sum = acc. Then {acc,preg} <= {1'b0, sum, preg} >> 1 (logical).
    - Signed: {preg[0],q_m1}=01 -> sum=acc+mcand; 10 -> sum=acc-mcand; 00/11 -> sum=acc. Then arithmetic shift right of {sum,preg,q_m1}, replicating sum[WIDTH].
    - cnt decrements each iteration; on the iteration where cnt==1, go to DONE.
  - DONE: done=1, busy=0 for exactly this state. Unconditionally leave to IDLE next cycle, unless start=1, which is accepted as in IDLE.
- Latency:
  - Start accepted at edge E0.
  - WIDTH RUN iterations on edges E1..EWIDTH.
  - done high in the cycle after EWIDTH.
  - Start-to-done = WIDTH+1 edges.
  - Back-to-back throughput: one result per WIDTH+1 cycles.
- Result hold: product/hi/lo are stable from done until the next accepted start; they do not clear on return to IDLE.
- Boundary conditions:
  - start while in RUN is ignored; no restart, operands not re-latched.
  - Operand and signed_mode changes after accept have no effect.
  - The (WIDTH+1)-bit acc prevents overflow for mcand = -2^(WIDTH-1) with subtract, and for carry-out in unsigned mode.
  - Reset asserted mid-RUN aborts immediately. After rst_n deasserts, the first start behaves as from power-up.
  - Zero operands still take the full WIDTH iterations; there is no early termination.
- Intermediate product values during RUN are not guaranteed; only done-qualified values are architectural.

Decomposition:
- Package mul_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - Booth pair encodings (BOOTH_NOP, BOOTH_ADD, BOOTH_SUB);
  - the unsigned/signed mode constants.
- Sub-module seq_mul_addsub:
  - combinational (WIDTH+1)-bit add/subtract;
  - inputs: acc, mcand, op (nop/add/sub);
  - output: sum.
- seq_multiplier instantiates seq_mul_addsub; the FSM, counter and shift register stay at top level.

Test Plan:
- WIDTH=32, unsigned, A=0xFFFFFFFF, B=0xFFFFFFFF, pulse start -> done exactly 33 edges later; product=0xFFFFFFFE00000001, hi=0xFFFFFFFE, lo=0x00000001; busy high for 32 cycles.
- WIDTH=32, signed, A=7, B=0xFFFFFFFD (-3) -> product=0xFFFFFFFFFFFFFFEB; then A=B=0x80000000 -> product=0x4000000000000000.
- WIDTH=32, unsigned, A=0x80000000, B=0x80000000 -> product=0x4000000000000000. Same operands signed with A=0xFFFFFFFF, B=0xFFFFFFFF -> product=0x0000000000000001.
- Start re-pulsed and operands changed at cycles 5 and 20 of a run (A=3, B=5 unsigned) -> single done, product=15, no extra done pulse.
- rst_n driven low mid-RUN (cycle 10) -> busy, done and product go 0 asynchronously. New start after release with A=2, B=9 -> product=18 after 33 edges.
- WIDTH=8: signed 0x80*0x80 -> 0x4000; unsigned 0x80*0x80 -> 0x4000; unsigned 0xFF*0xFF -> 0xFE01. Start held high in DONE cycle -> back-to-back results, done 9 edges apart.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-add / Booth multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_e;

    localparam logic MODE_UNSIGNED = 1'b0;
    localparam logic MODE_SIGNED   = 1'b1;

    // Unsigned mode adds on a set LSB; signed mode uses the radix-2 Booth pair.
    function automatic booth_op_e booth_decode(input logic mode,
                                               input logic p0,
                                               input logic qm1);
        booth_op_e res;
        res = BOOTH_NOP;
        if (mode == MODE_UNSIGNED) begin
            res = p0 ? BOOTH_ADD : BOOTH_NOP;
        end else begin
            case ({p0, qm1})
                2'b01:   res = BOOTH_ADD;
                2'b10:   res = BOOTH_SUB;
                default: res = BOOTH_NOP;
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_mul_addsub.sv
// Combinational (WIDTH+1)-bit add/subtract used by each multiplier iteration.
module seq_mul_addsub
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] acc_i,
    input  logic [WIDTH:0] mcand_i,
    input  booth_op_e      op_i,
    output logic [WIDTH:0] sum_o
);

    always_comb begin
        sum_o = acc_i;
        case (op_i)
            BOOTH_ADD: sum_o = acc_i + mcand_i;
            BOOTH_SUB: sum_o = acc_i - mcand_i;
            default:   sum_o = acc_i;
        endcase
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential multiplier: one shift-add (unsigned) or Booth (signed) step per cycle,
// start/busy/done handshake, result held until the next accepted start.
module seq_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     hi,
    output logic [WIDTH-1:0]     lo
);

    state_e           state_q, state_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic [WIDTH:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0] preg_q, preg_d;
    logic             qm1_q, qm1_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   sum;
    logic             shift_msb;
    logic             accept;
    booth_op_e        op;

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign op     = booth_decode(mode_q, preg_q[0], qm1_q);

    seq_mul_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .op_i    (op),
        .sum_o   (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (cnt_q == CNT_W'(1)) state_d = DONE;
            DONE:    state_d = accept ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_comb begin
        acc_d     = acc_q;
        preg_d    = preg_q;
        qm1_d     = qm1_q;
        mode_d    = mode_q;
        mcand_d   = mcand_q;
        cnt_d     = cnt_q;
        shift_msb = 1'b0;
        if (accept) begin
            acc_d   = '0;
            preg_d  = multiplier;
            qm1_d   = 1'b0;
            mode_d  = signed_mode;
            mcand_d = (signed_mode == MODE_SIGNED) ? {multiplicand[WIDTH-1], multiplicand}
                                                   : {1'b0, multiplicand};
            cnt_d   = CNT_W'(WIDTH);
        end else if (state_q == RUN) begin
            // Signed mode shifts arithmetically; unsigned shifts a zero in above the carry.
            shift_msb = (mode_q == MODE_SIGNED) ? sum[WIDTH] : 1'b0;
            acc_d     = {shift_msb, sum[WIDTH:1]};
            preg_d    = {sum[0], preg_q[WIDTH-1:1]};
            qm1_d     = preg_q[0];
            cnt_d     = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            preg_q  <= '0;
            qm1_q   <= 1'b0;
            mode_q  <= 1'b0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            preg_q  <= preg_d;
            qm1_q   <= qm1_d;
            mode_q  <= mode_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hi      = acc_q[WIDTH-1:0];
    assign lo      = preg_q;
    assign product = {hi, lo};

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at WIDTH=32 and WIDTH=8.
module tb_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start32, mode32, busy32, done32;
    logic [31:0] a32, b32, hi32, lo32;
    logic [63:0] prod32;
    logic        start8, mode8, busy8, done8;
    logic [7:0]  a8, b8, hi8, lo8;
    logic [15:0] prod8;

    seq_multiplier #(.WIDTH(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .signed_mode(mode32),
        .multiplicand(a32), .multiplier(b32), .busy(busy32), .done(done32),
        .product(prod32), .hi(hi32), .lo(lo32)
    );

    seq_multiplier #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(mode8),
        .multiplicand(a8), .multiplier(b8), .busy(busy8), .done(done8),
        .product(prod8), .hi(hi8), .lo(lo8)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] q32[$];
    logic [15:0] q8[$];

    typedef struct {
        bit          w8;
        logic        mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;
    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboards: every done pulse pops one expected result.
    logic [63:0] e32;
    always @(negedge clk) begin
        if (rst_n && done32) begin
            if (q32.size() == 0) begin
                chk("done32_unexpected", 64'(done32), 64'd0);
            end else begin
                e32 = q32.pop_front();
                chk("product32", prod32, e32);
                chk("hi32", 64'(hi32), 64'(e32[63:32]));
                chk("lo32", 64'(lo32), 64'(e32[31:0]));
                chk("busy32_in_done", 64'(busy32), 64'd0);
            end
        end
    end

    logic [15:0] e8;
    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                chk("done8_unexpected", 64'(done8), 64'd0);
            end else begin
                e8 = q8.pop_front();
                chk("product8", 64'(prod8), 64'(e8));
                chk("hi8", 64'(hi8), 64'(e8[15:8]));
                chk("lo8", 64'(lo8), 64'(e8[7:0]));
            end
        end
    end

    task automatic run_op(input bit w8, input logic mode, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, output int edges, output int busyc);
        edges = 0;
        busyc = 0;
        @(negedge clk);
        if (w8) begin
            a8 = a[7:0]; b8 = b[7:0]; mode8 = mode; start8 = 1'b1;
            q8.push_back(exp[15:0]);
        end else begin
            a32 = a; b32 = b; mode32 = mode; start32 = 1'b1;
            q32.push_back(exp);
        end
        @(posedge clk);
        edges = 1;
        #1;
        start8  = 1'b0;
        start32 = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (w8 ? done8 : done32) break;
            if (w8 ? busy8 : busy32) busyc++;
            @(posedge clk);
            edges++;
        end
    endtask

    int          edges, busyc, nd, done_at;
    bit          found;
    logic [63:0] last_exp;
    logic [31:0] ra, rb;
    logic        rm;
    logic signed [63:0] sa, sb;

    initial begin
        rst_n = 1'b0;
        start32 = 1'b0; mode32 = 1'b0; a32 = '0; b32 = '0;
        start8  = 1'b0; mode8  = 1'b0; a8  = '0; b8  = '0;
        last_exp = '0;

        vt.push_back('{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001});
        vt.push_back('{1'b0, 1'b1, 32'h00000007, 32'hFFFFFFFD, 64'hFFFFFFFFFFFFFFEB});
        vt.push_back('{1'b0, 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000});
        vt.push_back('{1'b0, 1'b0, 32'h80000000, 32'h80000000, 64'h4000000000000000});
        vt.push_back('{1'b0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001});
        vt.push_back('{1'b0, 1'b0, 32'h00000000, 32'h12345678, 64'h0000000000000000});
        vt.push_back('{1'b0, 1'b1, 32'h80000000, 32'h00000001, 64'hFFFFFFFF80000000});
        vt.push_back('{1'b0, 1'b1, 32'h7FFFFFFF, 32'h80000000, 64'hC000000080000000});
        vt.push_back('{1'b1, 1'b1, 32'h80, 32'h80, 64'h4000});
        vt.push_back('{1'b1, 1'b0, 32'h80, 32'h80, 64'h4000});
        vt.push_back('{1'b1, 1'b0, 32'hFF, 32'hFF, 64'hFE01});
        vt.push_back('{1'b1, 1'b1, 32'h07, 32'hFD, 64'hFFEB});
        vt.push_back('{1'b1, 1'b1, 32'hFF, 32'hFF, 64'h0001});
        vt.push_back('{1'b1, 1'b1, 32'h7F, 32'h80, 64'hC080});
        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom; rm = 1'($urandom_range(0, 1));
            sa = {{32{ra[31]}}, ra};
            sb = {{32{rb[31]}}, rb};
            vt.push_back('{1'b0, rm, ra, rb, rm ? 64'(sa * sb) : ({32'd0, ra} * {32'd0, rb})});
        end

        #12;
        chk("reset_busy32", 64'(busy32), 64'd0);
        chk("reset_done32", 64'(done32), 64'd0);
        chk("reset_product32", prod32, 64'd0);
        chk("reset_product8", 64'(prod8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            run_op(vt[i].w8, vt[i].mode, vt[i].a, vt[i].b, vt[i].exp, edges, busyc);
            chk($sformatf("latency_%0d", i), 64'(edges), vt[i].w8 ? 64'd9 : 64'd33);
            chk($sformatf("busy_cycles_%0d", i), 64'(busyc), vt[i].w8 ? 64'd8 : 64'd32);
            if (!vt[i].w8) last_exp = vt[i].exp;
        end

        // Result hold while idle with operands changing.
        @(negedge clk);
        a32 = 32'h13579BDF; b32 = 32'h2468ACE0; mode32 = ~mode32;
        repeat (4) @(negedge clk);
        chk("hold_product32", prod32, last_exp);

        // Start re-pulsed with new operands mid-run must be ignored.
        @(negedge clk);
        a32 = 32'd3; b32 = 32'd5; mode32 = 1'b0; start32 = 1'b1;
        q32.push_back(64'd15);
        @(posedge clk);
        #1 start32 = 1'b0;
        nd = 0; done_at = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done32) begin
                nd++;
                if (done_at == 0) done_at = c;
            end
            if (c == 5 || c == 20) begin
                start32 = 1'b1; a32 = 32'd1000 + 32'(c); b32 = 32'hFFFF0000; mode32 = 1'b1;
            end else begin
                start32 = 1'b0;
            end
        end
        start32 = 1'b0;
        chk("restart_done_count", 64'(nd), 64'd1);
        chk("restart_done_cycle", 64'(done_at), 64'd33);

        // Asynchronous reset mid-run.
        @(negedge clk);
        a32 = 32'd1234; b32 = 32'd5678; mode32 = 1'b0; start32 = 1'b1;
        @(posedge clk);
        #1 start32 = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy32", 64'(busy32), 64'd0);
        chk("abort_done32", 64'(done32), 64'd0);
        chk("abort_product32", prod32, 64'd0);
        chk("abort_hi32", 64'(hi32), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 1'b0, 32'd2, 32'd9, 64'd18, edges, busyc);
        chk("post_reset_latency", 64'(edges), 64'd33);

        // Back-to-back on WIDTH=8: start asserted during the DONE cycle.
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h80; mode8 = 1'b1; start8 = 1'b1;
        q8.push_back(16'h4000);
        @(posedge clk);
        #1 start8 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done8) begin
                found = 1'b1;
                break;
            end
        end
        chk("b2b_first_done", 64'(found), 64'd1);
        a8 = 8'hFF; b8 = 8'hFF; mode8 = 1'b0; start8 = 1'b1;
        q8.push_back(16'hFE01);
        edges = 0;
        @(posedge clk);
        edges = 1;
        #1 start8 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done8) break;
            @(posedge clk);
            edges++;
        end
        chk("b2b_done_spacing", 64'(edges), 64'd9);

        repeat (3) @(negedge clk);
        chk("scoreboard32_drained", 64'(q32.size()), 64'd0);
        chk("scoreboard8_drained", 64'(q8.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
